// File: rtl/pool_window_streamer_if.sv
// Pixel-in / window-out handshake bundle for the 2x2 pooling window streamer.
// The slave side is the streamer; the master side is the surrounding datapath.
interface pool_window_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] pix_in;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [DATA_WIDTH-1:0] win_tl;
  logic [DATA_WIDTH-1:0] win_tr;
  logic [DATA_WIDTH-1:0] win_bl;
  logic [DATA_WIDTH-1:0] win_br;
  logic                  win_valid;
  logic                  win_ready;
  logic                  win_last;

  modport master (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, win_tl, win_tr, win_bl, win_br, win_valid, win_last
  );

  modport slave (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, win_tl, win_tr, win_bl, win_br, win_valid, win_last
  );
endinterface

// File: rtl/pool_window_streamer.sv
// Streaming 2x2 stride-2 window generator. Buffers one even row, holds the
// odd-row left pixel, and loads a single-entry window register when the
// bottom-right pixel of a window arrives.
module pool_window_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pool_window_streamer_if.slave  bus
);
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]      col_reg, col_next;
  logic [ROW_W-1:0]      row_reg, row_next;
  logic [DATA_WIDTH-1:0] linebuf [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] hold_bl_reg;
  logic [DATA_WIDTH-1:0] win_tl_reg, win_tr_reg, win_bl_reg, win_br_reg;
  logic                  win_valid_reg, win_last_reg;

  logic                  pix_ready;
  logic                  pix_fire;
  logic                  odd_row, odd_col;
  logic                  win_load;
  logic [COL_W-1:0]      col_left;

  // Any pending window must be able to leave before another pixel is taken,
  // so a full window register stalls every pixel, not just completing ones.
  assign pix_ready = !rst && (!win_valid_reg || bus.win_ready);
  assign pix_fire  = bus.pix_valid && pix_ready;
  assign odd_row   = row_reg[0];
  assign odd_col   = col_reg[0];
  assign win_load  = pix_fire && odd_row && odd_col;
  // col is odd when a window completes, so the left column is simply col-1.
  assign col_left  = col_reg - COL_W'(1);

  // Raster position advance: column wraps into the next row, frame wraps to (0,0).
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (pix_fire) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        row_next = (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
      end else begin
        col_next = col_reg + COL_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  // Even rows fill the line buffer; it is never cleared because every entry
  // is rewritten on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (pix_fire && !odd_row) begin
      linebuf[col_reg] <= bus.pix_in;
    end
  end

  // Odd row, even column: keep the bottom-left pixel until its partner arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_bl_reg <= '0;
    end else if (pix_fire && odd_row && !odd_col) begin
      hold_bl_reg <= bus.pix_in;
    end
  end

  // Single-entry window register; a new load wins over a same-edge drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_tl_reg    <= '0;
      win_tr_reg    <= '0;
      win_bl_reg    <= '0;
      win_br_reg    <= '0;
      win_valid_reg <= 1'b0;
      win_last_reg  <= 1'b0;
    end else if (win_load) begin
      win_tl_reg    <= linebuf[col_left];
      win_tr_reg    <= linebuf[col_reg];
      win_bl_reg    <= hold_bl_reg;
      win_br_reg    <= bus.pix_in;
      win_valid_reg <= 1'b1;
      win_last_reg  <= (col_reg == COL_LAST) && (row_reg == ROW_LAST);
    end else if (bus.win_ready) begin
      win_valid_reg <= 1'b0;
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.win_tl    = win_tl_reg;
  assign bus.win_tr    = win_tr_reg;
  assign bus.win_bl    = win_bl_reg;
  assign bus.win_br    = win_br_reg;
  assign bus.win_valid = win_valid_reg;
  assign bus.win_last  = win_last_reg;
endmodule

// File: tb/tb_pool_window_streamer.sv
// Directed bench for pool_window_streamer: a 4x4 instance for the scenario
// tests and a default 8x8 instance for the full-size frame.
module tb_pool_window_streamer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pool_window_streamer_if #(.DATA_WIDTH(8)) bus4 ();
  pool_window_streamer_if #(.DATA_WIDTH(8)) bus8 ();

  pool_window_streamer #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  pool_window_streamer #(.DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  typedef struct packed {
    logic [7:0] tl;
    logic [7:0] tr;
    logic [7:0] bl;
    logic [7:0] br;
    logic       last;
  } win_t;

  win_t q4[$];
  win_t q8[$];
  int passed = 0;
  int total  = 0;

  // Record every window transfer (sampled on the falling edge before the transfer edge).
  always @(negedge clk) begin
    if (bus4.win_valid === 1'b1 && bus4.win_ready === 1'b1)
      q4.push_back(win_t'{bus4.win_tl, bus4.win_tr, bus4.win_bl, bus4.win_br, bus4.win_last});
    if (bus8.win_valid === 1'b1 && bus8.win_ready === 1'b1)
      q8.push_back(win_t'{bus8.win_tl, bus8.win_tr, bus8.win_bl, bus8.win_br, bus8.win_last});
  end

  function automatic win_t mk(input int tl, input int tr, input int bl, input int br, input bit last);
    win_t w;
    w.tl = tl[7:0]; w.tr = tr[7:0]; w.bl = bl[7:0]; w.br = br[7:0]; w.last = last;
    return w;
  endfunction

  // Hand-derived 4x4 windows: top-left pixels 0,2,8,10; only the 4th is last.
  function automatic win_t exp4(input int base, input int k);
    int tl_tab [4];
    int tl;
    tl_tab = '{0, 2, 8, 10};
    tl = base + tl_tab[k];
    return mk(tl, tl + 1, tl + 4, tl + 5, k == 3);
  endfunction

  function automatic win_t cur4();
    return win_t'{bus4.win_tl, bus4.win_tr, bus4.win_bl, bus4.win_br, bus4.win_last};
  endfunction

  task automatic send_pix(input bit big, input logic [7:0] v);
    int  n;
    logic rdy;
    n = 0;
    if (big) begin bus8.pix_in = v; bus8.pix_valid = 1'b1; end
    else     begin bus4.pix_in = v; bus4.pix_valid = 1'b1; end
    @(negedge clk);
    rdy = big ? bus8.pix_ready : bus4.pix_ready;
    while (rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      rdy = big ? bus8.pix_ready : bus4.pix_ready;
      n++;
    end
    total++;
    if (n >= 50) $display("FAIL send_timeout: pixel %0d pix_ready=%b required 1", v, rdy);
    else passed++;
    @(posedge clk); #1;
    if (big) bus8.pix_valid = 1'b0;
    else     bus4.pix_valid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus4.pix_valid = 1'b0; bus4.pix_in = '0; bus4.win_ready = 1'b1;
    bus8.pix_valid = 1'b0; bus8.pix_in = '0; bus8.win_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (bus4.pix_ready !== 1'b0) $display("FAIL reset_pix_ready4: got %b required 0", bus4.pix_ready); else passed++;
    total++;
    if (bus8.pix_ready !== 1'b0) $display("FAIL reset_pix_ready8: got %b required 0", bus8.pix_ready); else passed++;
    total++;
    if (cur4() !== mk(0, 0, 0, 0, 0)) $display("FAIL reset_outputs: got %h required %h", cur4(), mk(0, 0, 0, 0, 0)); else passed++;
    total++;
    if (bus4.win_valid !== 1'b0) $display("FAIL reset_win_valid: got %b required 0", bus4.win_valid); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus4.pix_ready !== 1'b1) $display("FAIL post_reset_ready: got %b required 1", bus4.pix_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit exp_v;
    int k;
    q4.delete();
    for (int i = 0; i < 16; i++) begin
      send_pix(1'b0, 8'(i));
      exp_v = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      total++;
      if (bus4.win_valid !== exp_v) $display("FAIL basic_valid_after_pix%0d: got %b required %b", i, bus4.win_valid, exp_v); else passed++;
      if (exp_v) begin
        k = (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : 3;
        total++;
        if (cur4() !== exp4(0, k)) $display("FAIL basic_window%0d: got %h required %h", k, cur4(), exp4(0, k)); else passed++;
      end
    end
    drain();
    total++;
    if (q4.size() != 4) $display("FAIL basic_count: got %0d required 4", q4.size()); else passed++;
  endtask

  task automatic test_backpressure();
    q4.delete();
    for (int i = 0; i < 6; i++) send_pix(1'b0, 8'(i));
    bus4.win_ready = 1'b0;
    bus4.pix_in    = 8'd6;
    bus4.pix_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus4.pix_ready !== 1'b0) $display("FAIL bp_pix_ready_c%0d: got %b required 0", c, bus4.pix_ready); else passed++;
      total++;
      if (bus4.win_valid !== 1'b1 || cur4() !== exp4(0, 0))
        $display("FAIL bp_stable_c%0d: got v=%b %h required v=1 %h", c, bus4.win_valid, cur4(), exp4(0, 0));
      else passed++;
      @(posedge clk); #1;
    end
    bus4.win_ready = 1'b1;
    for (int i = 6; i < 16; i++) send_pix(1'b0, 8'(i));
    drain();
    total++;
    if (q4.size() != 4) $display("FAIL bp_count: got %0d required 4", q4.size());
    else begin
      passed++;
      for (int k = 0; k < 4; k++) begin
        total++;
        if (q4[k] !== exp4(0, k)) $display("FAIL bp_window%0d: got %h required %h", k, q4[k], exp4(0, k)); else passed++;
      end
    end
  endtask

  task automatic test_gaps();
    q4.delete();
    for (int i = 0; i < 16; i++) begin
      send_pix(1'b0, 8'(i));
      if (i < 15) begin
        bus4.pix_in = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    drain();
    total++;
    if (q4.size() != 4) $display("FAIL gaps_count: got %0d required 4", q4.size());
    else begin
      passed++;
      for (int k = 0; k < 4; k++) begin
        total++;
        if (q4[k] !== exp4(0, k)) $display("FAIL gaps_window%0d: got %h required %h", k, q4[k], exp4(0, k)); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    q4.delete();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) send_pix(1'b0, 8'(f * 100 + i));
    drain();
    total++;
    if (q4.size() != 8) $display("FAIL b2b_count: got %0d required 8", q4.size());
    else begin
      passed++;
      for (int k = 0; k < 8; k++) begin
        total++;
        if (q4[k] !== exp4((k / 4) * 100, k % 4))
          $display("FAIL b2b_window%0d: got %h required %h", k, q4[k], exp4((k / 4) * 100, k % 4));
        else passed++;
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 7; i++) send_pix(1'b0, 8'(i));
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus4.pix_ready !== 1'b0) $display("FAIL midrst_pix_ready: got %b required 0", bus4.pix_ready); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (bus4.win_valid !== 1'b0 || cur4() !== mk(0, 0, 0, 0, 0))
      $display("FAIL midrst_outputs: got v=%b %h required v=0 %h", bus4.win_valid, cur4(), mk(0, 0, 0, 0, 0));
    else passed++;
    q4.delete();
    for (int i = 0; i < 16; i++) send_pix(1'b0, 8'(i));
    drain();
    total++;
    if (q4.size() != 4) $display("FAIL midrst_count: got %0d required 4", q4.size());
    else begin
      passed++;
      for (int k = 0; k < 4; k++) begin
        total++;
        if (q4[k] !== exp4(0, k)) $display("FAIL midrst_window%0d: got %h required %h", k, q4[k], exp4(0, k)); else passed++;
      end
    end
  endtask

  task automatic test_defaults();
    int n_last;
    q8.delete();
    for (int i = 0; i < 64; i++) send_pix(1'b1, 8'(i));
    drain();
    total++;
    if (q8.size() != 16) $display("FAIL def_count: got %0d required 16", q8.size());
    else begin
      passed++;
      total++;
      if (q8[0] !== mk(0, 1, 8, 9, 0)) $display("FAIL def_first: got %h required %h", q8[0], mk(0, 1, 8, 9, 0)); else passed++;
      total++;
      if (q8[15] !== mk(54, 55, 62, 63, 1)) $display("FAIL def_last: got %h required %h", q8[15], mk(54, 55, 62, 63, 1)); else passed++;
      n_last = 0;
      foreach (q8[k]) if (q8[k].last) n_last++;
      total++;
      if (n_last != 1) $display("FAIL def_last_count: got %0d required 1", n_last); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_defaults();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pool_window_streamer.md
# pool_window_streamer

Streaming 2x2 window generator that sits upstream of the CNN accelerator's pooling path and feeds its four-pixel window inputs. It accepts a raster-scan feature map one pixel per handshake, buffers one line internally, and emits non-overlapping 2x2 windows (stride 2) in top-left, top-right, bottom-left, bottom-right order. The output maps directly onto the accelerator's four window inputs (input1..input4), with a valid/ready handshake and an end-of-frame marker.

## Interface
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 8, pixels per row. Must be even and ≥2.
- IMG_HEIGHT, 8, rows per frame. Must be even and ≥2.
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pix_in  input  DATA_WIDTH  raster-order pixel.
- pix_valid  input  1  pix_in is valid.
- pix_ready  output  1  block can accept a pixel; a pixel transfers when pix_valid && pix_ready.
- win_tl, win_tr, win_bl, win_br  output  DATA_WIDTH each  window pixels; these drive input1, input2, input3, input4 respectively.
- win_valid  output  1  window outputs are valid.
- win_ready  input  1  downstream accepts the window; a window transfers when win_valid && win_ready.
- win_last  output  1  asserted with the final window of a frame.

## Operation
- Counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1.
  - Both advance only on a pixel transfer.
  - col wraps to 0 and row increments.
  - After pixel (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0, so the next frame starts with no idle cycle.
- Line buffer: IMG_WIDTH entries. Even rows write pix_in at index col.
- Odd rows, even col: the pixel is held in a register (hold_bl).
- Odd rows, odd col: this is the window-completing pixel. On the transfer edge, load:
  - win_tl = linebuf[col-1], win_tr = linebuf[col];
  - win_bl = hold_bl, win_br = pix_in;
  - win_valid = 1;
  - win_last = 1 iff col == IMG_WIDTH-1 && row == IMG_HEIGHT-1, else 0.
- Window register:
  - Single entry.
  - win_valid clears on a window transfer unless a new window loads on the same edge; a simultaneous load wins and keeps win_valid = 1.
  - Data and win_last are stable while win_valid && !win_ready.
- Flow control: pix_ready = !rst && (!win_valid || win_ready).
  - Stalls apply on every pixel, not only window-completing ones. This is deliberately conservative and cannot drop a window.
- Windows per frame: (IMG_WIDTH/2)·(IMG_HEIGHT/2), emitted in row-major window order.
- Arithmetic: none on pixel data. Values pass bit-exact and unsigned-agnostic.
- Counter widths: $clog2 of the respective dimension, minimum 1.
- Reset (also when asserted mid-frame):
  - col = 0, row = 0;
  - win_valid = 0, win_last = 0;
  - win_tl, win_tr, win_bl, win_br = 0;
  - hold_bl = 0.
  - Line buffer contents are not cleared. Every entry is rewritten before it is read.
  - A partially received window is discarded. The first pixel after reset is treated as (0,0).
- pix_valid low: counters hold. Gaps of any length are legal anywhere in the frame.

## Timing
- Latency: win_valid rises on the clock edge that transfers the window-completing (bottom-right) pixel, i.e. it is visible 1 cycle after that handshake.
- Throughput:
  - With win_ready held high, one pixel per cycle and no bubbles.
  - With win_ready low while win_valid is high, pix_ready is low in the same cycle (combinational from win_ready).
- Back-to-back: a window can transfer out and a new pixel can transfer in on the same edge.
- During rst: pix_ready = 0, and every output equals its reset value on the cycle after rst is sampled high.

## Test plan
- **4x4 frame, pixels 0..15, win_ready held high.**
  - Expect windows (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15).
  - Each window is valid 1 cycle after pixels 5, 7, 13 and 15 respectively.
  - win_last is set only on (10,11,14,15).
- **Backpressure.**
  - Stimulus: same 4x4 frame; drop win_ready for 3 cycles while window (0,1,4,5) is valid.
  - Window data stays stable and pix_ready = 0 for those 3 cycles.
  - No pixel is lost; the remaining windows match the first scenario.
- **Input gaps.**
  - Stimulus: toggle pix_valid 1,0,0,1 across the frame.
  - Windows are identical to the first scenario; counters do not advance on idle cycles.
- **Back-to-back frames.**
  - Stimulus: two 4x4 frames, values 0..15 then 100..115, with no gap.
  - The second frame's first window is (100,101,104,105), with no spurious window between frames.
- **Mid-frame reset.**
  - Stimulus: assert rst for 1 cycle after pixel 6, then send a full frame of 0..15.
  - win_valid = 0 and all window outputs = 0 after reset.
  - Exactly 4 correct windows follow.
- **Defaults (8x8, pixels 0..63).**
  - Exactly 16 windows; the first is (0,1,8,9) and the last is (54,55,62,63) with win_last = 1.
